// File: rtl/pipe_idexe_stage.sv
// ID/EXE pipeline register with operand-forward selection and load-use interlock.
// Inserts a one-cycle bubble on a load-use hazard and counts stall cycles (saturating).
module pipe_idexe_stage (
  input  logic        clock,
  input  logic        reset,
  // ID-stage controls and fields
  input  logic        dwreg,
  input  logic        dm2reg,
  input  logic        dwmem,
  input  logic        daluimm,
  input  logic        dshift,
  input  logic        djal,
  input  logic [3:0]  daluc,
  input  logic [31:0] dpc4,
  input  logic [31:0] da,
  input  logic [31:0] db,
  input  logic [31:0] dimm,
  input  logic [4:0]  drn,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        users,
  input  logic        usert,
  // MEM-stage destination info
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [4:0]  mrn,
  // EXE-stage registered outputs
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic        ealuimm,
  output logic        eshift,
  output logic        ejal,
  output logic [3:0]  ealuc,
  output logic [31:0] epc4,
  output logic [31:0] ea,
  output logic [31:0] eb,
  output logic [31:0] eimm,
  output logic [4:0]  ern,
  // Hazard outputs
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        stall,
  output logic        wpcir,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    FWD_NONE     = 2'b00,
    FWD_EXE_ALU  = 2'b01,
    FWD_MEM_ALU  = 2'b10,
    FWD_MEM_LOAD = 2'b11
  } fwd_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic exe_writes;
  logic mem_writes;
  logic exe_load;
  fwd_e fwd_a_sel;
  fwd_e fwd_b_sel;

  // Register 0 is hardwired, so a producer targeting it is never a hazard source.
  assign exe_writes = ewreg & (ern != 5'd0);
  assign mem_writes = mwreg & (mrn != 5'd0);
  assign exe_load   = exe_writes & em2reg;

  assign stall = exe_load & ((users & (ern == drs)) | (usert & (ern == drt)));
  assign wpcir = ~stall;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_a_sel = FWD_NONE;
    if (exe_writes && !em2reg && (ern == drs))
      fwd_a_sel = FWD_EXE_ALU;
    else if (mem_writes && (mrn == drs))
      fwd_a_sel = mm2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
  end

  always_comb begin
    fwd_b_sel = FWD_NONE;
    if (exe_writes && !em2reg && (ern == drt))
      fwd_b_sel = FWD_EXE_ALU;
    else if (mem_writes && (mrn == drt))
      fwd_b_sel = mm2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
  end

  assign fwda = fwd_a_sel;
  assign fwdb = fwd_b_sel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      ewreg     <= 1'b0;
      em2reg    <= 1'b0;
      ewmem     <= 1'b0;
      ealuimm   <= 1'b0;
      eshift    <= 1'b0;
      ejal      <= 1'b0;
      ealuc     <= 4'd0;
      epc4      <= 32'd0;
      ea        <= 32'd0;
      eb        <= 32'd0;
      eimm      <= 32'd0;
      ern       <= 5'd0;
      stall_cnt <= 16'd0;
    end else begin
      // A bubble only needs its side-effecting controls cleared.
      ewreg   <= dwreg  & ~stall;
      em2reg  <= dm2reg & ~stall;
      ewmem   <= dwmem  & ~stall;
      ejal    <= djal   & ~stall;
      ealuimm <= daluimm;
      eshift  <= dshift;
      ealuc   <= daluc;
      epc4    <= dpc4;
      ea      <= da;
      eb      <= db;
      eimm    <= dimm;
      ern     <= drn;
      if (stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pipe_idexe_stage.md
PIPE_IDEXE_STAGE -- requirements
Module: pipe_idexe_stage

Interface
REQ-001 Parameters: none; all widths fixed (32-bit datapath, 5-bit register numbers, 4-bit aluc).
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 dwreg, dm2reg, dwmem, daluimm, dshift, djal  in  1 each  ID-stage controls from control unit.
REQ-005 daluc  in  4  ID-stage ALU control.
REQ-006 dpc4, da, db, dimm  in  32 each  ID-stage PC+4, rs operand, rt operand, extended immediate.
REQ-007 drn  in  5  ID-stage destination register; drs, drt  in  5 each  ID-stage source register numbers.
REQ-008 users, usert  in  1 each  current ID instruction reads rs / rt.
REQ-009 mwreg, mm2reg  in  1 each; mrn  in  5  MEM-stage write enable, load flag, destination.
REQ-010 ewreg, em2reg, ewmem, ealuimm, eshift, ejal  out  1 each  registered EXE-stage controls.
REQ-011 ealuc  out  4; epc4, ea, eb, eimm  out  32 each; ern  out  5  registered EXE-stage fields.
REQ-012 fwda, fwdb  out  2 each  combinational operand-forward selects for ID stage.
REQ-013 stall  out  1  combinational load-use interlock; wpcir  out  1  = ~stall (PC / IF-ID write enable).
REQ-014 stall_cnt  out  16  registered count of stall cycles.

Function
REQ-015 stall = ewreg & em2reg & (ern != 0) & ((users & ern == drs) | (usert & ern == drt)).
REQ-016 fwda: 01 if ewreg & ern!=0 & ern==drs & ~em2reg; else 10 if mwreg & mrn!=0 & mrn==drs & ~mm2reg; else 11 if mwreg & mrn!=0 & mrn==drs & mm2reg; else 00.
REQ-017 fwdb: identical rule using drt in place of drs.
REQ-018 EXE-stage match has priority over MEM-stage match; register 0 never forwards nor stalls.
REQ-019 Forward selects are computed regardless of users/usert; stall alone uses users/usert.
REQ-020 Normal cycle (stall=0): all E outputs load corresponding d inputs on next edge; latency exactly 1 cycle.
REQ-021 Stall cycle: ewreg, ewmem, em2reg, ejal load 0 (bubble); ealuc, ealuimm, eshift, epc4, ea, eb, eimm, ern still load d inputs.
REQ-022 Bubble never writes register file or memory; ID instruction is retained upstream via wpcir=0 and re-presented next cycle.
REQ-023 A stall lasts exactly one cycle per load-use pair: the bubble clears ewreg, so REQ-015 deasserts the following cycle.
REQ-024 stall_cnt increments by 1 on each edge where stall=1; saturates at 16'hFFFF (no wrap).
REQ-025 Back-to-back stalls (separate load pairs) each count once.
REQ-026 Outputs fwda/fwdb/stall/wpcir are purely combinational from inputs and E registers; no internal state beyond E registers and stall_cnt.

Reset
REQ-027 While reset=1 at an edge: all E outputs load 0, stall_cnt loads 0; reset overrides stall and d inputs.
REQ-028 After reset, stall=0, wpcir=1, fwda=fwdb=00 until non-zero MEM inputs arrive.
REQ-029 Reset asserted mid-stall: next cycle E outputs 0, stall_cnt 0, stall deasserted.

Verification
REQ-030 Load-use: cycle 1 drive lw (dwreg=1,dm2reg=1,drn=5); cycle 2 drive add drs=5 users=1 -> stall=1, wpcir=0; cycle 3 ewreg=0, stall=0, fwda=11 (mrn=5,mm2reg=1), stall_cnt=1.
REQ-031 ALU forward priority: ewreg=1,ern=3,em2reg=0 and mwreg=1,mrn=3,mm2reg=0, drs=drt=3 -> fwda=fwdb=01.
REQ-032 Register zero: lw with drn=0 followed by user of drs=0 -> stall=0, fwda=00.
REQ-033 Saturation: force 65536 stall cycles -> stall_cnt holds 16'hFFFF.
REQ-034 Pass-through: stall=0, dpc4=32'h0000_0040, daluc=4'b0101, dimm=32'hFFFF_FFFC -> next cycle epc4, ealuc, eimm match.
REQ-035 Reset mid-operation: reset=1 during stall cycle -> next edge all E outputs 0, stall_cnt=0.
